// File: rtl/hk_spi_pkg.sv
// hk_spi_pkg -- shared definitions for the housekeeping SPI slave.
//   state_t       : frame FSM encodings (command, address, data, pass-through)
//   CMD_*         : bit positions inside the command byte
//   RD_MISS_FILL  : byte shifted out when read data was not acknowledged in time
// Optional feature macro: HK_SPI_PASSTHRU_EN adds the pass-through state.
package hk_spi_pkg;

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_ADDR = 2'd1,
`ifdef HK_SPI_PASSTHRU_EN
    ST_DATA = 2'd2,
    ST_PASS = 2'd3
`else
    ST_DATA = 2'd2
`endif
  } state_t;

  localparam int CMD_WR     = 7;
  localparam int CMD_RD     = 6;
  localparam int CMD_NNN_HI = 5;
  localparam int CMD_NNN_LO = 3;
  localparam int CMD_MGMT   = 2;
  localparam int CMD_USER   = 1;

  localparam logic [7:0] RD_MISS_FILL = 8'h00;

endpackage

// File: rtl/hk_spi_sync.sv
// hk_spi_sync -- multi-flop synchroniser for one asynchronous pin, followed by
// an edge-detect register producing single-cycle rise/fall events.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous pin
//   lvl        : synchronised level
//   rise, fall : one-clock event pulses, aligned with lvl
// RESET_VAL is the idle level of the pin so that reset produces no edge.
module hk_spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= {SYNC_STAGES{RESET_VAL}};
      lvl_p1  <= RESET_VAL;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      // edge-detect stage
      lvl_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_p0[SYNC_STAGES-1];
  assign rise =  lvl & ~lvl_p1;
  assign fall = ~lvl &  lvl_p1;

endmodule

// File: rtl/hk_spi_slave.sv
// hk_spi_slave -- housekeeping SPI slave (mode 0, msb first), fully clocked by
// the system clock; the SPI pins are oversampled.
// Frame: command byte, ADDR_BYTES address bytes, then data bytes.
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   spi_sck/spi_csb/spi_sdi  asynchronous SPI pins
//   spi_sdo, spi_sdoenb      serial data out and its active-low enable
//   oaddr, odata             register address and write data
//   wrstb, rdstb             one-clock write / read-request strobes
//   idata, rdack             read data and its acknowledge
//   pass_thru_mgmt/user      flash pass-through active
//   busy                     synchronised CSB low
//   rd_miss                  sticky: read byte shifted before rdack arrived
// Optional feature macro: HK_SPI_PASSTHRU_EN (pass-through state and outputs).
module hk_spi_slave
  import hk_spi_pkg::*;
#(
  parameter int ADDR_BYTES  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_sck,
  input  logic                    spi_csb,
  input  logic                    spi_sdi,
  output logic                    spi_sdo,
  output logic                    spi_sdoenb,
  output logic [8*ADDR_BYTES-1:0] oaddr,
  output logic [7:0]              odata,
  output logic                    wrstb,
  output logic                    rdstb,
  input  logic [7:0]              idata,
  input  logic                    rdack,
  output logic                    pass_thru_mgmt,
  output logic                    pass_thru_user,
  output logic                    busy,
  output logic                    rd_miss
);

  localparam int AW = 8 * ADDR_BYTES;

  logic sck_lvl, sck_rise, sck_fall;
  logic csb_lvl, csb_rise, csb_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_ev;

  state_t     state, state_next;
  logic [4:0] bit_cnt;
  logic [6:0] sr_in;
  logic [7:0] byte_in;
  logic [7:0] sr_out;
  logic [7:0] rd_buf;
  logic       cmd_wr, cmd_rd;
  logic [2:0] cmd_nnn, cnt_rem;
  logic       inc_pend, rd_next, rd_pending, rd_buf_vld;
  logic       rise_ev, fall_ev, final_byte;

  hk_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .din(spi_sck), .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  hk_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk(clk), .reset(reset), .din(spi_csb), .lvl(csb_lvl), .rise(csb_rise), .fall(csb_fall)
  );
  hk_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .din(spi_sdi), .lvl(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  assign unused_ev = ^{sck_lvl, csb_rise, csb_fall, sdi_rise, sdi_fall};

  // CSB high gates every SCK event, so an abort always wins over a coincident edge.
  assign rise_ev    = sck_rise & ~csb_lvl;
  assign fall_ev    = sck_fall & ~csb_lvl;
  assign byte_in    = {sr_in, sdi_lvl};
  assign final_byte = (cmd_nnn != 3'd0) && (cnt_rem == 3'd1);

  always_comb begin
    state_next = state;
    case (state)
      ST_CMD: begin
        if (rise_ev && bit_cnt == 5'd7) begin
          state_next = ST_ADDR;
`ifdef HK_SPI_PASSTHRU_EN
          if (byte_in[CMD_MGMT] || byte_in[CMD_USER]) state_next = ST_PASS;
`endif
        end
      end
      ST_ADDR: if (rise_ev && bit_cnt == 5'(AW - 1)) state_next = ST_DATA;
      ST_DATA: if (rise_ev && bit_cnt == 5'd7 && final_byte) state_next = ST_CMD;
      default: state_next = state;
    endcase
    if (csb_lvl) state_next = ST_CMD;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CMD;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || csb_lvl) begin
      bit_cnt    <= '0;
      sr_in      <= '0;
      sr_out     <= '0;
      rd_buf     <= '0;
      oaddr      <= '0;
      odata      <= '0;
      cmd_wr     <= 1'b0;
      cmd_rd     <= 1'b0;
      cmd_nnn    <= '0;
      cnt_rem    <= '0;
      wrstb      <= 1'b0;
      rdstb      <= 1'b0;
      inc_pend   <= 1'b0;
      rd_next    <= 1'b0;
      rd_pending <= 1'b0;
      rd_buf_vld <= 1'b0;
      rd_miss    <= 1'b0;
    end else begin
      wrstb <= 1'b0;
      rdstb <= 1'b0;

      // Acknowledge only counts while a request is outstanding.
      if (rdack && rd_pending) begin
        rd_buf     <= idata;
        rd_buf_vld <= 1'b1;
        rd_pending <= 1'b0;
      end

      // Address advances one clock after the byte event so that wrstb sees
      // the address of the byte just written; the next read is requested
      // together with the advanced address.
      if (inc_pend) begin
        inc_pend <= 1'b0;
        oaddr    <= oaddr + AW'(1);
        if (rd_next) begin
          rdstb      <= 1'b1;
          rd_pending <= 1'b1;
        end
      end

      if (rise_ev) begin
        sr_in <= byte_in[6:0];
        case (state)
          ST_CMD: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              cmd_wr  <= byte_in[CMD_WR];
              cmd_rd  <= byte_in[CMD_RD];
              cmd_nnn <= byte_in[CMD_NNN_HI:CMD_NNN_LO];
              cnt_rem <= byte_in[CMD_NNN_HI:CMD_NNN_LO];
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_ADDR: begin
            oaddr <= {oaddr[AW-2:0], sdi_lvl};
            if (bit_cnt == 5'(AW - 1)) begin
              bit_cnt <= '0;
              if (cmd_rd) begin
                rdstb      <= 1'b1;
                rd_pending <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_DATA: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              inc_pend <= 1'b1;
              rd_next  <= cmd_rd && !final_byte;
              if (cmd_wr) begin
                odata <= byte_in;
                wrstb <= 1'b1;
              end
              if (cmd_nnn != 3'd0) cnt_rem <= cnt_rem - 3'd1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end

      // The first fall of each read byte either loads acknowledged data or,
      // when nothing arrived, the fill value and the sticky miss flag.
      if (fall_ev && state == ST_DATA && cmd_rd) begin
        if (bit_cnt == 5'd0) begin
          rd_buf_vld <= 1'b0;
          if (rd_buf_vld) begin
            sr_out <= rd_buf;
          end else begin
            sr_out     <= RD_MISS_FILL;
            rd_miss    <= 1'b1;
            rd_pending <= 1'b0;
          end
        end else begin
          sr_out <= {sr_out[6:0], 1'b0};
        end
      end
    end
  end

`ifdef HK_SPI_PASSTHRU_EN
  logic pass_mgmt_q, pass_user_q;

  always_ff @(posedge clk) begin
    if (reset || csb_lvl) begin
      pass_mgmt_q <= 1'b0;
      pass_user_q <= 1'b0;
    end else if (state == ST_CMD && rise_ev && bit_cnt == 5'd7 &&
                 (byte_in[CMD_MGMT] || byte_in[CMD_USER])) begin
      // mgmt wins when both pass bits are set
      pass_mgmt_q <= byte_in[CMD_MGMT];
      pass_user_q <= ~byte_in[CMD_MGMT];
    end
  end

  assign pass_thru_mgmt = pass_mgmt_q;
  assign pass_thru_user = pass_user_q;
  assign spi_sdoenb     = ~((state == ST_DATA && cmd_rd) || state == ST_PASS);
`else
  assign pass_thru_mgmt = 1'b0;
  assign pass_thru_user = 1'b0;
  assign spi_sdoenb     = ~(state == ST_DATA && cmd_rd);
`endif

  assign spi_sdo = sr_out[7];
  assign busy    = ~csb_lvl;

endmodule

// File: tb/tb_hk_spi_slave.sv
// tb_hk_spi_slave -- directed and randomized frames against a byte-level
// frame model; two instances cover 1-byte and 2-byte addressing.
module tb_hk_spi_slave;

  localparam int H = 8;

  logic clk, reset, spi_sck, spi_sdi, csb1, csb2;
  logic sdo1, sdoenb1, wrstb1, rdstb1, rdack1, pm1, pu1, busy1, miss1;
  logic sdo2, sdoenb2, wrstb2, rdstb2, rdack2, pm2, pu2, busy2, miss2;
  logic [7:0]  oaddr1, odata1, idata1, odata2, idata2;
  logic [15:0] oaddr2;

  hk_spi_slave #(.ADDR_BYTES(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_csb(csb1), .spi_sdi(spi_sdi),
    .spi_sdo(sdo1), .spi_sdoenb(sdoenb1), .oaddr(oaddr1), .odata(odata1),
    .wrstb(wrstb1), .rdstb(rdstb1), .idata(idata1), .rdack(rdack1),
    .pass_thru_mgmt(pm1), .pass_thru_user(pu1), .busy(busy1), .rd_miss(miss1)
  );

  hk_spi_slave #(.ADDR_BYTES(2), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_csb(csb2), .spi_sdi(spi_sdi),
    .spi_sdo(sdo2), .spi_sdoenb(sdoenb2), .oaddr(oaddr2), .odata(odata2),
    .wrstb(wrstb2), .rdstb(rdstb2), .idata(idata2), .rdack(rdack2),
    .pass_thru_mgmt(pm2), .pass_thru_user(pu2), .busy(busy2), .rd_miss(miss2)
  );

  int checks = 0;
  int errors = 0;
  int sel = 1;
  bit ack_en = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] ra;

  logic [7:0]  frame[$];
  logic [7:0]  rx[$];
  logic [15:0] got_wa[$];
  logic [7:0]  got_wd[$];
  logic [15:0] exp_wa[$];
  logic [7:0]  exp_wd[$];
  int          exp_rx_idx[$];
  logic [7:0]  exp_rx_val[$];
  logic        exp_pm, exp_pu, exp_sdoenb, exp_miss;
  logic [15:0] exp_oaddr;
  logic        mid_pm, mid_pu, mid_sdoenb, mid_miss, mid_busy;
  logic [15:0] mid_oaddr;
  logic        post_miss, post_sdoenb, post_busy, post_pm;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-file responder for the 1-byte-address instance: ack 2 clk after rdstb.
  initial begin
    rdack1 = 1'b0; idata1 = 8'h00; rdack2 = 1'b0; idata2 = 8'h00;
    forever begin
      @(negedge clk);
      if (rdstb1 && ack_en) begin
        ra = oaddr1;
        repeat (2) @(posedge clk);
        #1; rdack1 = 1'b1; idata1 = mem[ra];
        @(posedge clk);
        #1; rdack1 = 1'b0; idata1 = 8'h00;
      end
    end
  end

  // Write-strobe recorder.
  initial begin
    forever begin
      @(negedge clk);
      if (wrstb1) begin got_wa.push_back({8'h00, oaddr1}); got_wd.push_back(odata1); end
      if (wrstb2) begin got_wa.push_back(oaddr2); got_wd.push_back(odata2); end
    end
  end

  // Frame model: walks the bytes of a frame as the master sent them.
  task automatic model(input int aw);
    int i, n, k;
    logic [7:0]  c;
    logic [15:0] a, mask;
    i = 0; a = '0;
    mask = (aw == 16) ? 16'hFFFF : 16'h00FF;
    exp_wa.delete(); exp_wd.delete(); exp_rx_idx.delete(); exp_rx_val.delete();
    exp_pm = 1'b0; exp_pu = 1'b0; exp_sdoenb = 1'b1; exp_miss = 1'b0;
    while (i < frame.size()) begin
      c = frame[i]; i++;
`ifdef HK_SPI_PASSTHRU_EN
      if (c[2] || c[1]) begin
        exp_pm = c[2]; exp_pu = !c[2]; exp_sdoenb = 1'b0;
        break;
      end
`endif
      a = '0;
      for (int j = 0; j < aw / 8; j++)
        if (i < frame.size()) begin a = ((a << 8) | {8'h00, frame[i]}) & mask; i++; end
      n = (c[5:3] == 3'd0) ? frame.size() - i : int'(c[5:3]);
      k = 0;
      while (k < n && i < frame.size()) begin
        if (c[7]) begin exp_wa.push_back(a); exp_wd.push_back(frame[i]); end
        if (c[6]) begin
          exp_rx_idx.push_back(i);
          exp_rx_val.push_back(ack_en ? mem[a[7:0]] : 8'h00);
          if (!ack_en) exp_miss = 1'b1;
        end
        a = (a + 16'd1) & mask; i++; k++;
      end
      exp_sdoenb = (c[5:3] == 3'd0 || k < n) ? !c[6] : 1'b1;
    end
    exp_oaddr = a;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int b = 7; b > 7 - nb; b--) begin
      spi_sdi = tx[b];
      clks(H);
      r[b] = (sel == 1) ? sdo1 : sdo2;
      spi_sck = 1'b1;
      clks(H);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame();
    logic [7:0] r;
    got_wa.delete(); got_wd.delete(); rx.delete();
    if (sel == 1) csb1 = 1'b0; else csb2 = 1'b0;
    clks(H);
    foreach (frame[j]) begin
      spi_bits(frame[j], 8, r);
      rx.push_back(r);
    end
    clks(H);
    mid_pm     = (sel == 1) ? pm1 : pm2;
    mid_pu     = (sel == 1) ? pu1 : pu2;
    mid_sdoenb = (sel == 1) ? sdoenb1 : sdoenb2;
    mid_miss   = (sel == 1) ? miss1 : miss2;
    mid_busy   = (sel == 1) ? busy1 : busy2;
    mid_oaddr  = (sel == 1) ? {8'h00, oaddr1} : oaddr2;
    csb1 = 1'b1; csb2 = 1'b1;
    clks(8);
    post_miss   = (sel == 1) ? miss1 : miss2;
    post_sdoenb = (sel == 1) ? sdoenb1 : sdoenb2;
    post_busy   = (sel == 1) ? busy1 : busy2;
    post_pm     = (sel == 1) ? pm1 : pm2;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nwr"}, got_wa.size(), exp_wa.size());
    for (int j = 0; j < exp_wa.size() && j < got_wa.size(); j++) begin
      check({tag, "_waddr"}, got_wa[j], exp_wa[j]);
      check({tag, "_wdata"}, got_wd[j], exp_wd[j]);
    end
    foreach (exp_rx_idx[j]) check({tag, "_rx"}, rx[exp_rx_idx[j]], exp_rx_val[j]);
    check({tag, "_busy"}, mid_busy, 1'b1);
    check({tag, "_sdoenb"}, mid_sdoenb, exp_sdoenb);
    check({tag, "_miss"}, mid_miss, exp_miss);
    check({tag, "_pm"}, mid_pm, exp_pm);
    check({tag, "_pu"}, mid_pu, exp_pu);
    check({tag, "_oaddr"}, mid_oaddr, exp_oaddr);
    check({tag, "_post_miss"}, post_miss, 1'b0);
    check({tag, "_post_sdoenb"}, post_sdoenb, 1'b1);
    check({tag, "_post_busy"}, post_busy, 1'b0);
    check({tag, "_post_pm"}, post_pm, 1'b0);
  endtask

  task automatic do_frame(input string tag, input int aw);
    model(aw);
    run_frame();
    check_frame(tag);
  endtask

  initial begin
    logic [7:0] r, d;
    logic wr, rd;
    logic [2:0] nnn;
    int nb;
    reset = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0; csb1 = 1'b1; csb2 = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    clks(5);

    check("rst_sdo", sdo1, 1'b0);
    check("rst_sdoenb", sdoenb1, 1'b1);
    check("rst_oaddr", oaddr1, 8'h00);
    check("rst_odata", odata1, 8'h00);
    check("rst_wrstb", wrstb1, 1'b0);
    check("rst_rdstb", rdstb1, 1'b0);
    check("rst_pm", pm1, 1'b0);
    check("rst_pu", pu1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_miss", miss1, 1'b0);
    reset = 1'b0;
    clks(5);

    // single-byte write, then a second command in the same frame
    sel = 1;
    frame = '{8'h88, 8'h10, 8'hA5, 8'h88, 8'h20, 8'h5A};
    do_frame("t1_write", 8);

    // stream read across the address wrap
    mem[8'hFE] = 8'hFE; mem[8'hFF] = 8'hFF; mem[8'h00] = 8'h00;
    frame = '{8'h40, 8'hFE, 8'($urandom), 8'($urandom), 8'($urandom)};
    do_frame("t2_stream", 8);

    // no acknowledge: fill byte and sticky miss
    ack_en = 1'b0;
    frame = '{8'h48, 8'($urandom), 8'($urandom)};
    do_frame("t3_miss", 8);
    ack_en = 1'b1;

    // abort after 5 data bits
    got_wa.delete(); got_wd.delete();
    csb1 = 1'b0;
    clks(H);
    spi_bits(8'h88, 8, r);
    spi_bits(8'h30, 8, r);
    spi_bits(8'($urandom), 5, r);
    clks(H);
    csb1 = 1'b1;
    clks(8);
    check("t4_abort_nwr", got_wa.size(), 0);
    check("t4_abort_busy", busy1, 1'b0);
    check("t4_abort_sdoenb", sdoenb1, 1'b1);
    frame = '{8'h88, 8'($urandom), 8'($urandom)};
    do_frame("t4_after", 8);

    // pass-through command (normal r/w stream when the feature is absent)
    frame = '{8'hC4, 8'h40, 8'($urandom)};
    do_frame("t5_pass", 8);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      wr  = 1'($urandom);
      rd  = wr ? 1'($urandom) : 1'b1;
      nnn = 3'($urandom_range(0, 3));
      nb  = (nnn != 3'd0) ? int'(nnn) : $urandom_range(1, 4);
      frame = '{{wr, rd, nnn, 3'b000}, 8'($urandom)};
      for (int j = 0; j < nb; j++) frame.push_back(8'($urandom));
      do_frame("rand", 8);
    end

    // 2-byte address: two writes, then reset mid-frame
    sel = 2;
    frame = '{8'h90, 8'h12, 8'h34, 8'h11, 8'h22};
    do_frame("t6_aw16", 16);

    got_wa.delete(); got_wd.delete();
    csb2 = 1'b0;
    clks(H);
    spi_bits(8'h90, 8, r);
    spi_bits(8'h12, 8, r);
    spi_bits(8'h34, 8, r);
    d = 8'($urandom);
    spi_bits(d, 8, r);
    clks(2);
    reset = 1'b1;
    clks(2);
    check("t6_rst_sdoenb", sdoenb2, 1'b1);
    check("t6_rst_oaddr", oaddr2, 16'h0000);
    check("t6_rst_odata", odata2, 8'h00);
    check("t6_rst_wrstb", wrstb2, 1'b0);
    check("t6_rst_busy", busy2, 1'b0);
    check("t6_rst_miss", miss2, 1'b0);
    check("t6_rst_sdo", sdo2, 1'b0);
    reset = 1'b0;
    spi_bits(8'h22, 8, r);
    clks(H);
    csb2 = 1'b1;
    clks(8);
    check("t6_rst_nwr", got_wa.size(), 1);
    if (got_wa.size() > 0) begin
      check("t6_rst_waddr", got_wa[0], 16'h1234);
      check("t6_rst_wdata", got_wd[0], d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
